// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted write buffer between the data cache memory port and Data_Memory.
// Evicted dirty lines are acknowledged in one cycle and drained in the background. Refill reads
// are served from the youngest matching buffered line, or go to memory ahead of further drains.
// Build option: define WBUF_COALESCE_EN to merge a write into an already-buffered copy of the
// same line (the head entry is excluded while it is being written to memory).
module dcache_write_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cache_enable_i,
   input  logic              cache_write_i,
   input  logic [ADDR_W-1:0] cache_addr_i,
   input  logic [DATA_W-1:0] cache_data_i,
   output logic              cache_ack_o,
   output logic [DATA_W-1:0] cache_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned TAG_W = ADDR_W - 5;

   typedef enum logic [1:0] {StIdle, StRdMem, StWrMem} state_e;

   // Line storage
   logic [DEPTH-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   // Memory-side FSM and registered outputs
   state_e            r_state;
   state_e            w_state_d;
   logic              r_ack;
   logic [DATA_W-1:0] r_rdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;

   logic              w_ack_d;
   logic [DATA_W-1:0] w_rdata_d;
   logic              w_mem_en_d;
   logic              w_mem_we_d;
   logic [ADDR_W-1:0] w_mem_addr_d;
   logic [DATA_W-1:0] w_mem_data_d;

   // Request decode
   logic [TAG_W-1:0]  w_req_tag;
   logic              w_req;
   logic              w_full;
   logic              w_pop;
   logic              w_rd_hit;
   logic [PTR_W-1:0]  w_rd_idx;
   logic [PTR_W-1:0]  w_rd_scan;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_coal;
   logic [PTR_W-1:0]  w_coal_idx;
   logic              w_wr_req;
   logic              w_do_enq;
   logic              w_do_coal;
   logic              w_rd_req;
   logic              w_fwd;
   logic              w_rd_miss;

   // A request held across its own ack cycle is only sampled again once the ack has dropped.
   assign w_req_tag = cache_addr_i[ADDR_W-1:5];
   assign w_req     = cache_enable_i & ~r_ack;
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop     = (r_state == StWrMem) & mem_ack_i;

   // Scan oldest to youngest so the last match found is the youngest copy of the line.
   always_comb begin
      w_rd_hit  = 1'b0;
      w_rd_idx  = '0;
      w_rd_scan = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_rd_scan = r_head + PTR_W'(i);
         if (r_valid[w_rd_scan] && (r_tag[w_rd_scan] == w_req_tag)) begin
            w_rd_hit = 1'b1;
            w_rd_idx = w_rd_scan;
         end
      end
   end

   assign w_rd_data = r_data[w_rd_idx];

`ifdef WBUF_COALESCE_EN
   logic [PTR_W-1:0] w_coal_scan;

   // Find a buffered copy to overwrite; the head is off limits while it is on the memory bus.
   always_comb begin
      w_coal      = 1'b0;
      w_coal_idx  = '0;
      w_coal_scan = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_coal_scan = r_head + PTR_W'(i);
         if (r_valid[w_coal_scan] && (r_tag[w_coal_scan] == w_req_tag) &&
             !((w_coal_scan == r_head) && (r_state == StWrMem))) begin
            w_coal     = 1'b1;
            w_coal_idx = w_coal_scan;
         end
      end
   end
`else
   assign w_coal     = 1'b0;
   assign w_coal_idx = '0;
`endif

   // A full buffer can still accept a write on the edge that retires the head.
   assign w_wr_req  = w_req & cache_write_i;
   assign w_do_coal = w_wr_req & w_coal;
   assign w_do_enq  = w_wr_req & ~w_coal & (~w_full | w_pop);
   assign w_rd_req  = w_req & ~cache_write_i;
   assign w_fwd     = w_rd_req & w_rd_hit;
   assign w_rd_miss = w_rd_req & ~w_rd_hit;

   // Pointers, occupancy and valid bits; an enqueue into the slot being popped keeps it valid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         if (w_do_enq) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_do_enq) - CNT_W'(w_pop);
      end
   end

   // Line tag/data payload; qualified by r_valid so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_do_enq) begin
         r_tag[r_tail]  <= w_req_tag;
         r_data[r_tail] <= cache_data_i;
      end
      if (w_do_coal) begin
         r_data[w_coal_idx] <= cache_data_i;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next state: a pending read miss always wins over starting another drain.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_rd_miss) begin
               w_state_d = StRdMem;
            end else if (r_count != '0) begin
               w_state_d = StWrMem;
            end
         end
         StRdMem: begin
            if (mem_ack_i) begin
               w_state_d = StIdle;
            end
         end
         StWrMem: begin
            if (mem_ack_i) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs for both ports.
   always_comb begin
      w_mem_en_d   = r_mem_en;
      w_mem_we_d   = r_mem_we;
      w_mem_addr_d = r_mem_addr;
      w_mem_data_d = r_mem_data;
      w_rdata_d    = r_rdata;
      w_ack_d      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_rd_miss) begin
               w_mem_en_d   = 1'b1;
               w_mem_we_d   = 1'b0;
               w_mem_addr_d = cache_addr_i;
            end else if (r_count != '0) begin
               w_mem_en_d   = 1'b1;
               w_mem_we_d   = 1'b1;
               w_mem_addr_d = {r_tag[r_head], 5'b0};
               w_mem_data_d = r_data[r_head];
            end
         end
         StRdMem: begin
            if (mem_ack_i) begin
               w_mem_en_d = 1'b0;
               w_rdata_d  = mem_data_i;
               w_ack_d    = 1'b1;
            end
         end
         StWrMem: begin
            if (mem_ack_i) begin
               w_mem_en_d = 1'b0;
            end
         end
         default: w_mem_en_d = 1'b0;
      endcase
      if (w_do_enq || w_do_coal || w_fwd) begin
         w_ack_d = 1'b1;
      end
      if (w_fwd) begin
         w_rdata_d = w_rd_data;
      end
   end

   // Output registers; reset abandons any in-flight memory request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ack      <= 1'b0;
         r_rdata    <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else begin
         r_ack      <= w_ack_d;
         r_rdata    <= w_rdata_d;
         r_mem_en   <= w_mem_en_d;
         r_mem_we   <= w_mem_we_d;
         r_mem_addr <= w_mem_addr_d;
         r_mem_data <= w_mem_data_d;
      end
   end

   assign cache_ack_o  = r_ack;
   assign cache_data_o = r_rdata;
   assign mem_enable_o = r_mem_en;
   assign mem_write_o  = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: randomized and directed bench for dcache_write_buffer with a
// queue-based model of the buffered lines and a responding memory model.
module tb_dcache_write_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 256;
   localparam int TAG_W  = ADDR_W - 5;

`ifdef WBUF_COALESCE_EN
   localparam bit CoalEn = 1'b1;
`else
   localparam bit CoalEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cache_enable_i;
   logic              cache_write_i;
   logic [ADDR_W-1:0] cache_addr_i;
   logic [DATA_W-1:0] cache_data_i;
   logic              cache_ack_o;
   logic [DATA_W-1:0] cache_data_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;

   always #5 clk = ~clk;

   dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i          (clk),
      .rst_i          (rst_n),
      .cache_enable_i (cache_enable_i),
      .cache_write_i  (cache_write_i),
      .cache_addr_i   (cache_addr_i),
      .cache_data_i   (cache_data_i),
      .cache_ack_o    (cache_ack_o),
      .cache_data_o   (cache_data_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_ack_i      (mem_ack_i),
      .mem_data_i     (mem_data_i)
   );

   int checks = 0;
   int failures = 0;

   // Model: lines posted but not yet written to memory, oldest first, plus memory contents.
   logic [TAG_W-1:0]  q_tag  [$];
   logic [DATA_W-1:0] q_data [$];
   logic [DATA_W-1:0] mem_model [logic [TAG_W-1:0]];

   // Memory responder state and transaction log.
   int                delay_min = 0;
   int                delay_max = 0;
   bit                rsp_busy;
   int                rsp_wait;
   bit                wr_inflight;
   bit                pop_pending;
   bit                rsp_ack_wr;
   bit                samp_inflight;
   bit                popped_now;
   bit                prev_ack;
   bit                rd_expect;
   logic [ADDR_W-1:0] rd_expect_addr;
   int                mem_reqs;
   bit                log_we   [$];
   logic [ADDR_W-1:0] log_addr [$];
   logic [DATA_W-1:0] log_data [$];

   function automatic logic [DATA_W-1:0] default_line(input logic [TAG_W-1:0] t);
      logic [31:0] w;
      w = 32'hECFA_0000 ^ {t, 5'b0};
      return {8{w}};
   endfunction

   function automatic logic [DATA_W-1:0] mem_read(input logic [TAG_W-1:0] t);
      if (mem_model.exists(t)) return mem_model[t];
      return default_line(t);
   endfunction

   function automatic bit coal_match(input logic [TAG_W-1:0] t, input bit excl_head);
      foreach (q_tag[i]) begin
         if (q_tag[i] == t && !(i == 0 && excl_head)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_write(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                                       input bit excl_head);
      if (CoalEn) begin
         for (int i = q_tag.size() - 1; i >= 0; i--) begin
            if (q_tag[i] == t && !(i == 0 && excl_head)) begin
               q_data[i] = d;
               return;
            end
         end
      end
      q_tag.push_back(t);
      q_data.push_back(d);
   endfunction

   function automatic int count_wr(input int from, input logic [ADDR_W-1:0] addr);
      int n = 0;
      for (int i = from; i < log_we.size(); i++) begin
         if (log_we[i] && log_addr[i] == addr) n++;
      end
      return n;
   endfunction

   // One clock: advance, then act as the memory and check drains against the model.
   task automatic tick();
      @(posedge clk);
      #1;
      samp_inflight = wr_inflight;
      popped_now    = 1'b0;
      rsp_ack_wr    = 1'b0;
      mem_ack_i     = 1'b0;
      if (!rst_n) begin
         rsp_busy    = 1'b0;
         wr_inflight = 1'b0;
         pop_pending = 1'b0;
         prev_ack    = 1'b0;
         return;
      end
      if (pop_pending) begin
         mem_model[q_tag[0]] = q_data[0];
         void'(q_tag.pop_front());
         void'(q_data.pop_front());
         pop_pending = 1'b0;
         wr_inflight = 1'b0;
         popped_now  = 1'b1;
      end
      checks++;
      if (prev_ack && cache_ack_o) begin
         failures++;
         $display("FAIL ack_pulse: cache_ack_o high %0d consecutive cycles, required 1", 2);
      end
      prev_ack = cache_ack_o;
      if (mem_enable_o) begin
         if (!rsp_busy) begin
            rsp_busy = 1'b1;
            mem_reqs++;
            rsp_wait = $urandom_range(delay_max, delay_min);
            if (mem_write_o) wr_inflight = 1'b1;
         end
         if (rsp_wait == 0) begin
            mem_ack_i = 1'b1;
            rsp_busy  = 1'b0;
            log_we.push_back(mem_write_o);
            log_addr.push_back(mem_addr_o);
            log_data.push_back(mem_write_o ? mem_data_o : '0);
            checks++;
            if (mem_write_o) begin
               rsp_ack_wr = 1'b1;
               if (q_tag.size() == 0) begin
                  failures++;
                  $display("FAIL drain_unexpected: got write %h, required no write", mem_addr_o);
               end else begin
                  if (mem_addr_o !== {q_tag[0], 5'b0} || mem_data_o !== q_data[0]) begin
                     failures++;
                     $display("FAIL drain_order: got %h/%h required %h/%h", mem_addr_o,
                              mem_data_o, {q_tag[0], 5'b0}, q_data[0]);
                  end
                  pop_pending = 1'b1;
               end
            end else begin
               if (!rd_expect || mem_addr_o[ADDR_W-1:5] !== rd_expect_addr[ADDR_W-1:5]) begin
                  failures++;
                  $display("FAIL mem_read: got read %h, expected pending miss %0d at %h",
                           mem_addr_o, rd_expect, rd_expect_addr);
               end
               rd_expect  = 1'b0;
               mem_data_i = mem_read(mem_addr_o[ADDR_W-1:5]);
            end
         end else begin
            rsp_wait--;
         end
      end
   endtask

   task automatic set_delay(input int lo, input int hi);
      delay_min = lo;
      delay_max = hi;
   endtask

   task automatic cache_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              output int lat);
      bit fast;
      if (cache_ack_o) tick();
      fast = (q_tag.size() < DEPTH) || rsp_ack_wr ||
             (CoalEn && coal_match(addr[ADDR_W-1:5], wr_inflight));
      cache_enable_i = 1'b1;
      cache_write_i  = 1'b1;
      cache_addr_i   = addr;
      cache_data_i   = data;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cache_ack_o && lat < 400);
      cache_enable_i = 1'b0;
      checks++;
      if (!cache_ack_o) begin
         failures++;
         $display("FAIL write_ack_timeout: addr %h got no ack in %0d cycles", addr, lat);
      end else begin
         model_write(addr[ADDR_W-1:5], data, samp_inflight && !popped_now);
         checks++;
         if (fast && lat != 1) begin
            failures++;
            $display("FAIL write_latency: addr %h got %0d cycles required 1", addr, lat);
         end else if (!fast && lat == 1) begin
            failures++;
            $display("FAIL write_stall: addr %h got %0d cycles required >1 (full)", addr, lat);
         end
      end
   endtask

   task automatic cache_read(input logic [ADDR_W-1:0] addr, output int lat);
      bit                hit;
      logic [DATA_W-1:0] exp;
      if (cache_ack_o) tick();
      hit = 1'b0;
      exp = '0;
      foreach (q_tag[i]) begin
         if (q_tag[i] == addr[ADDR_W-1:5]) begin
            hit = 1'b1;
            exp = q_data[i];
         end
      end
      rd_expect      = !hit;
      rd_expect_addr = addr;
      cache_enable_i = 1'b1;
      cache_write_i  = 1'b0;
      cache_addr_i   = addr;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!cache_ack_o && lat < 400);
      cache_enable_i = 1'b0;
      rd_expect      = 1'b0;
      checks++;
      if (!cache_ack_o) begin
         failures++;
         $display("FAIL read_ack_timeout: addr %h got no ack in %0d cycles", addr, lat);
      end else begin
         if (!hit) exp = mem_read(addr[ADDR_W-1:5]);
         if (cache_data_o !== exp) begin
            failures++;
            $display("FAIL read_data: addr %h got %h required %h", addr, cache_data_o, exp);
         end
         if (hit) begin
            checks++;
            if (lat != 1) begin
               failures++;
               $display("FAIL read_fwd_latency: addr %h got %0d cycles required 1", addr, lat);
            end
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q_tag.size() != 0 || mem_enable_o || pop_pending) && n < 600) begin
         tick();
         n++;
      end
      checks++;
      if (q_tag.size() != 0 || mem_enable_o) begin
         failures++;
         $display("FAIL drain_timeout: %0d lines still buffered, required 0", q_tag.size());
      end
   endtask

   task automatic wait_inflight();
      int n = 0;
      while (!(mem_enable_o && mem_write_o) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!(mem_enable_o && mem_write_o)) begin
         failures++;
         $display("FAIL drain_start_timeout: mem write got %b required 1", mem_enable_o);
      end
   endtask

   task automatic apply_reset();
      cache_enable_i = 1'b0;
      rst_n          = 1'b0;
      rd_expect      = 1'b0;
      mem_ack_i      = 1'b0;
      q_tag.delete();
      q_data.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks += 3;
      if (cache_ack_o !== 1'b0 || cache_data_o !== '0) begin
         failures++;
         $display("FAIL reset_cache: got ack %b data %h required 0", cache_ack_o, cache_data_o);
      end
      if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mem_ctl: got en %b we %b required 0", mem_enable_o, mem_write_o);
      end
      if (mem_addr_o !== '0 || mem_data_o !== '0) begin
         failures++;
         $display("FAIL reset_mem_bus: got %h/%h required 0", mem_addr_o, mem_data_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_drain();
      int lat;
      int base = log_we.size();
      set_delay(2, 2);
      cache_write(32'h0000_0200, {8{32'hAAAA_0001}}, lat);
      wait_idle();
      checks++;
      if (count_wr(base, 32'h0000_0200) != 1) begin
         failures++;
         $display("FAIL write_drain: got %0d writes to 0200 required 1", count_wr(base, 32'h200));
      end
   endtask

   task automatic test_read_forward();
      int lat;
      int base = log_we.size();
      set_delay(10, 10);
      cache_write(32'h0000_0200, {8{32'hAAAA_0002}}, lat);
      cache_read(32'h0000_0204, lat);
      wait_idle();
      checks++;
      if (log_we.size() - base != 1) begin
         failures++;
         $display("FAIL read_forward_traffic: got %0d mem ops required 1", log_we.size() - base);
      end
   endtask

   task automatic test_read_miss_latency();
      int lat;
      set_delay(3, 3);
      cache_read(32'h0000_0060, lat);
      checks++;
      if (lat != 5) begin
         failures++;
         $display("FAIL read_miss_latency: got %0d cycles required 5", lat);
      end
   endtask

   task automatic test_full_stall();
      int lat;
      int base = log_we.size();
      logic [ADDR_W-1:0] order [5];
      order = '{32'h1000, 32'h1020, 32'h1040, 32'h1060, 32'h0400};
      set_delay(15, 15);
      for (int i = 0; i < 5; i++) begin
         cache_write(order[i], {8{32'hF000_0000 | i}}, lat);
         if (i == 4) begin
            checks++;
            if (log_we.size() - base != 1) begin
               failures++;
               $display("FAIL full_ack_timing: got %0d drains done at ack required 1",
                        log_we.size() - base);
            end
         end
      end
      wait_idle();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (base + i >= log_addr.size() || log_addr[base + i] !== order[i]) begin
            failures++;
            $display("FAIL full_drain_order: entry %0d got %h required %h", i,
                     (base + i < log_addr.size()) ? log_addr[base + i] : '0, order[i]);
         end
      end
   endtask

   task automatic test_miss_during_drain();
      int lat;
      int base = log_we.size();
      set_delay(6, 6);
      cache_write(32'h0000_2000, {8{32'h1111_1111}}, lat);
      cache_write(32'h0000_2020, {8{32'h2222_2222}}, lat);
      wait_inflight();
      cache_read(32'h0000_0040, lat);
      wait_idle();
      checks++;
      if (log_we.size() - base != 3 || log_addr[base] !== 32'h2000 ||
          log_addr[base + 1] !== 32'h0040 || log_we[base + 1] !== 1'b0 ||
          log_addr[base + 2] !== 32'h2020) begin
         failures++;
         $display("FAIL miss_priority: got %0d ops, second at %h required W2000,R0040,W2020",
                  log_we.size() - base, (log_we.size() > base + 1) ? log_addr[base + 1] : '0);
      end
   endtask

   task automatic test_coalesce();
      int lat;
      int base = log_we.size();
      int exp_n = CoalEn ? 1 : 2;
      set_delay(12, 12);
      cache_write(32'h0000_0000, {8{32'h0BAD_F00D}}, lat);
      wait_inflight();
      cache_write(32'h0000_0220, {8{32'hAAAA_AAAA}}, lat);
      cache_write(32'h0000_0220, {8{32'hBBBB_BBBB}}, lat);
      wait_idle();
      checks += 2;
      if (count_wr(base, 32'h0000_0220) != exp_n) begin
         failures++;
         $display("FAIL coalesce_count: got %0d writes required %0d",
                  count_wr(base, 32'h220), exp_n);
      end
      if (log_data[log_data.size() - 1] !== {8{32'hBBBB_BBBB}}) begin
         failures++;
         $display("FAIL coalesce_data: got %h required B", log_data[log_data.size() - 1]);
      end
      // Same line while it is the head being written: must allocate in either build.
      base = log_we.size();
      cache_write(32'h0000_0240, {8{32'hCCCC_CCCC}}, lat);
      wait_inflight();
      cache_write(32'h0000_0240, {8{32'hDDDD_DDDD}}, lat);
      wait_idle();
      checks++;
      if (count_wr(base, 32'h0000_0240) != 2) begin
         failures++;
         $display("FAIL coalesce_head: got %0d writes required 2", count_wr(base, 32'h240));
      end
   endtask

   task automatic test_random();
      int lat;
      logic [ADDR_W-1:0] a;
      set_delay(0, 4);
      for (int i = 0; i < 300; i++) begin
         a = {22'h0, 5'($urandom_range(5, 0)) + 5'd8, 5'($urandom_range(31, 0))};
         if ($urandom_range(9, 0) < 6) begin
            cache_write(a, {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom}, lat);
         end else begin
            cache_read(a, lat);
         end
         repeat ($urandom_range(2, 0)) tick();
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_drain();
      int lat;
      int reqs;
      set_delay(30, 30);
      cache_write(32'h0000_3000, {8{32'h3333_3333}}, lat);
      wait_inflight();
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_mem: got en %b we %b required 0", mem_enable_o, mem_write_o);
      end
      if (cache_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ack: got %b required 0", cache_ack_o);
      end
      q_tag.delete();
      q_data.delete();
      tick();
      tick();
      rst_n = 1'b1;
      reqs  = mem_reqs;
      repeat (20) tick();
      checks++;
      if (mem_reqs != reqs) begin
         failures++;
         $display("FAIL reset_mid_traffic: got %0d new mem requests required 0", mem_reqs - reqs);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      cache_enable_i = 1'b0;
      cache_write_i  = 1'b0;
      cache_addr_i   = '0;
      cache_data_i   = '0;
      mem_ack_i      = 1'b0;
      mem_data_i     = '0;
      mem_reqs       = 0;
      test_reset();
      test_write_drain();
      test_read_forward();
      test_read_miss_latency();
      test_full_stall();
      test_miss_during_drain();
      test_coalesce();
      test_random();
      test_reset_mid_drain();
      apply_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
